ibex_isr_fetch_descrambler: RTL and testbench

Parametrised, pipelined instruction-set-randomisation descrambler that sits between the prefetch/fetch FIFO and the compressed decoder. It holds a bank of programmable keys and decodes each fetched word with `key XOR word-address`, producing either a 32-bit or a 16-bit (compressed) plaintext. The output is registered behind a valid/ready handshake. It supports key locking, an unprogrammed-key fault and an accepted-fetch counter.

---
 rtl/ibex_isr_fetch_descrambler.sv | 218 +++++++++++++++++++++
 tb/tb_ibex_isr_fetch_descrambler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_isr_fetch_descrambler.sv
// ibex_isr_fetch_descrambler
//
// Instruction-set-randomisation descrambler placed between the fetch FIFO and
// the compressed decoder. Each fetched word is decoded with
// (key XOR word address) using one of NumKeys programmable key banks. The
// result goes into a single output register behind a valid/ready handshake.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   in_valid_i/ready_o   fetch handshake
//   in_instr_i           scrambled fetch word (compressed uses [15:0])
//   in_addr_i            word address of the fetch (PC[31:2])
//   in_key_sel_i         key bank used for this fetch
//   out_valid_o/ready_i  plaintext handshake
//   out_instr_o          descrambled word
//   out_compressed_o     word is a 16-bit instruction
//   out_illegal_o        unprogrammed key, or compressed while disabled
//   flush_i              drop the held output word
//   key_we_i, key_idx_i  key bank write strobe and bank index
//   key32/16_wdata_i     new key values
//   key_lock_i           sticky lock request
//   key_locked_o         lock state
//   key_err_o            one-cycle pulse when a write was rejected
//   fetch_cnt_o          accepted fetches, saturating
module ibex_isr_fetch_descrambler #(
  parameter int          NumKeys          = 4,
  parameter logic [29:0] DefaultKey32     = 30'h3464_0911,
  parameter logic [13:0] DefaultKey16     = 14'h2844,
  parameter bit          EnableCompressed = 1'b1,
  parameter int          CntWidth         = 32,
  localparam int         KeyIdxW          = (NumKeys > 1) ? $clog2(NumKeys) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         in_instr_i,
  input  logic [29:0]         in_addr_i,
  input  logic [KeyIdxW-1:0]  in_key_sel_i,

  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_instr_o,
  output logic                out_compressed_o,
  output logic                out_illegal_o,

  input  logic                flush_i,

  input  logic                key_we_i,
  input  logic [KeyIdxW-1:0]  key_idx_i,
  input  logic [29:0]         key32_wdata_i,
  input  logic [13:0]         key16_wdata_i,
  input  logic                key_lock_i,
  output logic                key_locked_o,
  output logic                key_err_o,

  output logic [CntWidth-1:0] fetch_cnt_o
);

  // ---------------------------------------------------------------------------
  // Lock and write acceptance
  // ---------------------------------------------------------------------------
  logic lock_q, lock_d;
  logic key_err_q, key_err_d;
  logic write_ok;

  // A write in the same cycle the lock is requested is already rejected.
  assign write_ok  = key_we_i & ~lock_q & ~key_lock_i;
  assign lock_d    = lock_q | key_lock_i;
  assign key_err_d = key_we_i & (lock_q | key_lock_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      key_err_q <= key_err_d;
    end
  end

  assign key_locked_o = lock_q;
  assign key_err_o    = key_err_q;

  // ---------------------------------------------------------------------------
  // Key banks
  // ---------------------------------------------------------------------------
  logic [29:0] key32_vec [NumKeys];
  logic [13:0] key16_vec [NumKeys];
  logic        prog_vec  [NumKeys];

  for (genvar gi = 0; gi < NumKeys; gi++) begin : gen_bank
    logic [29:0] key32_q;
    logic [13:0] key16_q;
    logic        prog_q;
    logic        bank_we;

    assign bank_we = write_ok & (key_idx_i == KeyIdxW'(gi));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        key32_q <= (gi == 0) ? DefaultKey32 : 30'h0;
        key16_q <= (gi == 0) ? DefaultKey16 : 14'h0;
        prog_q  <= (gi == 0);
      end else if (bank_we) begin
        key32_q <= key32_wdata_i;
        key16_q <= key16_wdata_i;
        prog_q  <= 1'b1;
      end
    end

    assign key32_vec[gi] = key32_q;
    assign key16_vec[gi] = key16_q;
    assign prog_vec[gi]  = prog_q;
  end

  // Bank selection; a selector beyond NumKeys matches nothing and therefore
  // reads as an unprogrammed bank.
  logic [29:0] sel_key32;
  logic [13:0] sel_key16;
  logic        sel_prog;

  always_comb begin
    sel_key32 = 30'h0;
    sel_key16 = 14'h0;
    sel_prog  = 1'b0;
    for (int i = 0; i < NumKeys; i++) begin
      if (in_key_sel_i == KeyIdxW'(i)) begin
        sel_key32 = key32_vec[i];
        sel_key16 = key16_vec[i];
        sel_prog  = prog_vec[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Descramble
  // ---------------------------------------------------------------------------
  logic        is_comp;
  logic [31:0] d32;
  logic [15:0] d16;
  logic [31:0] dec_word;
  logic        dec_illegal;

  assign is_comp     = (in_instr_i[1:0] != 2'b11);
  assign d32         = {in_instr_i[31:2] ^ sel_key32 ^ in_addr_i, in_instr_i[1:0]};
  assign d16         = {in_instr_i[15:2] ^ sel_key16 ^ in_addr_i[13:0], in_instr_i[1:0]};
  assign dec_word    = is_comp ? {16'h0, d16} : d32;
  assign dec_illegal = ~sel_prog | (is_comp & !EnableCompressed);

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_comp_q,  out_comp_d;
  logic        out_ill_q,   out_ill_d;
  logic        in_hs;

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign in_hs      = in_valid_i & in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_comp_d  = out_comp_q;
    out_ill_d   = out_ill_q;
    if (flush_i) begin
      // Flush wins over a concurrent fetch; the fetch is dropped.
      out_valid_d = 1'b0;
    end else if (in_hs) begin
      out_valid_d = 1'b1;
      out_instr_d = dec_word;
      out_comp_d  = is_comp;
      out_ill_d   = dec_illegal;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_comp_q  <= 1'b0;
      out_ill_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_comp_q  <= out_comp_d;
      out_ill_q   <= out_ill_d;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_instr_o      = out_instr_q;
  assign out_compressed_o = out_comp_q;
  assign out_illegal_o    = out_ill_q;

  // ---------------------------------------------------------------------------
  // Fetch counter (counts flushed fetches too)
  // ---------------------------------------------------------------------------
  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign cnt_d = (in_hs && (cnt_q != {CntWidth{1'b1}})) ? cnt_q + CntWidth'(1) : cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_ibex_isr_fetch_descrambler.sv
// Directed testbench for ibex_isr_fetch_descrambler. A second instance with
// compressed support disabled shares all inputs with the main instance.
module tb_ibex_isr_fetch_descrambler;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [29:0] in_addr;
  logic [1:0]  in_key_sel;
  logic        out_ready;
  logic        flush;
  logic        key_we;
  logic [1:0]  key_idx;
  logic [29:0] key32_wdata;
  logic [13:0] key16_wdata;
  logic        key_lock;

  logic        in_ready, out_valid, out_comp, out_ill, key_locked, key_err;
  logic [31:0] out_instr, fetch_cnt;

  logic        nc_in_ready, nc_out_valid, nc_out_comp, nc_out_ill, nc_key_locked, nc_key_err;
  logic [31:0] nc_out_instr, nc_fetch_cnt;

  int checks   = 0;
  int failures = 0;

  ibex_isr_fetch_descrambler u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_instr_i       (in_instr),
    .in_addr_i        (in_addr),
    .in_key_sel_i     (in_key_sel),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_instr_o      (out_instr),
    .out_compressed_o (out_comp),
    .out_illegal_o    (out_ill),
    .flush_i          (flush),
    .key_we_i         (key_we),
    .key_idx_i        (key_idx),
    .key32_wdata_i    (key32_wdata),
    .key16_wdata_i    (key16_wdata),
    .key_lock_i       (key_lock),
    .key_locked_o     (key_locked),
    .key_err_o        (key_err),
    .fetch_cnt_o      (fetch_cnt)
  );

  ibex_isr_fetch_descrambler #(.EnableCompressed(1'b0)) u_nc (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .in_ready_o       (nc_in_ready),
    .in_instr_i       (in_instr),
    .in_addr_i        (in_addr),
    .in_key_sel_i     (in_key_sel),
    .out_valid_o      (nc_out_valid),
    .out_ready_i      (out_ready),
    .out_instr_o      (nc_out_instr),
    .out_compressed_o (nc_out_comp),
    .out_illegal_o    (nc_out_ill),
    .flush_i          (flush),
    .key_we_i         (key_we),
    .key_idx_i        (key_idx),
    .key32_wdata_i    (key32_wdata),
    .key16_wdata_i    (key16_wdata),
    .key_lock_i       (key_lock),
    .key_locked_o     (nc_key_locked),
    .key_err_o        (nc_key_err),
    .fetch_cnt_o      (nc_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [29:0] addr, input logic [1:0] sel);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_addr    = addr;
    in_key_sel = sel;
  endtask

  function automatic logic [31:0] stream_word(int i);
    logic [29:0] hi;
    hi = 30'h1357_9BD0 + 30'(i * 7);
    return {hi, 2'b11};
  endfunction

  function automatic logic [31:0] stream_exp(int i);
    logic [31:0] w;
    w = stream_word(i);
    return {w[31:2] ^ 30'h3464_0911 ^ 30'(i), w[1:0]};
  endfunction

  int sent;
  int rcvd;
  logic [31:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_addr = '0; in_key_sel = '0;
    out_ready = 1'b1; flush = 1'b0; key_we = 1'b0; key_idx = '0;
    key32_wdata = '0; key16_wdata = '0; key_lock = 1'b0;

    // Reset state
    cyc(); cyc();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_comp", 32'(out_comp), 32'h0);
    check("rst_out_ill", 32'(out_ill), 32'h0);
    check("rst_locked", 32'(key_locked), 32'h0);
    check("rst_key_err", 32'(key_err), 32'h0);
    check("rst_fetch_cnt", fetch_cnt, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    cyc();
    $display("step reset done");

    // 32-bit decode with the default key
    fetch(32'hD190_2457, 30'h0, 2'd0);
    cyc();
    in_valid = 1'b0;
    check("t32_valid", 32'(out_valid), 32'h1);
    check("t32_instr", out_instr, 32'h0000_0013);
    check("t32_comp", 32'(out_comp), 32'h0);
    check("t32_ill", 32'(out_ill), 32'h0);
    $display("step 32-bit decode instr=%h", out_instr);

    // Compressed decode, addr 0 then addr 1 back to back
    fetch(32'h0000_A111, 30'h0, 2'd0);
    cyc();
    check("t16a_instr", out_instr, 32'h0000_0001);
    check("t16a_comp", 32'(out_comp), 32'h1);
    check("t16a_ill", 32'(out_ill), 32'h0);
    check("nc_t16a_ill", 32'(nc_out_ill), 32'h1);
    check("nc_t16a_instr", nc_out_instr, 32'h0000_0001);
    fetch(32'h0000_A111, 30'h1, 2'd0);
    cyc();
    in_valid = 1'b0;
    check("t16b_valid", 32'(out_valid), 32'h1);
    check("t16b_instr", out_instr, 32'h0000_0005);
    check("t16b_comp", 32'(out_comp), 32'h1);
    cyc();
    check("t16_drain_valid", 32'(out_valid), 32'h0);
    $display("step compressed decode");

    // Unprogrammed bank 2
    fetch(32'h0000_0013, 30'h0, 2'd2);
    cyc();
    in_valid = 1'b0;
    check("unprog_ill", 32'(out_ill), 32'h1);
    check("unprog_instr", out_instr, 32'h0000_0013);
    // Program bank 2 with zero keys
    key_we = 1'b1; key_idx = 2'd2; key32_wdata = 30'h0; key16_wdata = 14'h0;
    cyc();
    key_we = 1'b0;
    fetch(32'h0000_0013, 30'h0, 2'd2);
    cyc();
    in_valid = 1'b0;
    check("prog_ill", 32'(out_ill), 32'h0);
    check("prog_instr", out_instr, 32'h0000_0013);
    // Same-cycle write and fetch: fetch sees the old key
    key_we = 1'b1; key_idx = 2'd2; key32_wdata = 30'h1; key16_wdata = 14'h0;
    fetch(32'h0000_0013, 30'h0, 2'd2);
    cyc();
    key_we = 1'b0;
    check("samecyc_old_key", out_instr, 32'h0000_0013);
    fetch(32'h0000_0013, 30'h0, 2'd2);
    cyc();
    in_valid = 1'b0;
    check("samecyc_new_key", out_instr, 32'h0000_0017);
    $display("step key programming");

    // Lock, with a write in the same cycle, then a write while locked
    key_lock = 1'b1; key_we = 1'b1; key_idx = 2'd0; key32_wdata = 30'h3FFF_FFFF; key16_wdata = 14'h3FFF;
    cyc();
    key_lock = 1'b0; key_we = 1'b0;
    check("lock_err_pulse", 32'(key_err), 32'h1);
    check("lock_locked", 32'(key_locked), 32'h1);
    cyc();
    check("lock_err_single", 32'(key_err), 32'h0);
    key_we = 1'b1;
    cyc();
    key_we = 1'b0;
    check("locked_write_err", 32'(key_err), 32'h1);
    fetch(32'hD190_2457, 30'h0, 2'd0);
    cyc();
    in_valid = 1'b0;
    check("locked_write_err_single", 32'(key_err), 32'h0);
    check("locked_bank0_instr", out_instr, 32'h0000_0013);
    check("cnt_before_reset", fetch_cnt, 32'd8);
    $display("step lock");

    // Reset, then stream 8 fetches with out_ready toggling
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("relock_cleared", 32'(key_locked), 32'h0);
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 60 && rcvd < 8; c++) begin
      out_ready  = (c % 2 == 0);
      in_valid   = (sent < 8);
      in_instr   = stream_word(sent);
      in_addr    = 30'(sent);
      in_key_sel = 2'd0;
      #1;
      if (out_valid && out_ready) begin
        check("stream_data", out_instr, stream_exp(rcvd));
        $display("stream recv %0d instr=%h", rcvd, out_instr);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_rcvd", 32'(rcvd), 32'd8);
    check("stream_cnt", fetch_cnt, 32'd8);
    cyc();
    check("stream_no_dup", 32'(out_valid), 32'h0);

    // Flush a held word
    out_ready = 1'b0;
    fetch(32'hD190_2457, 30'h0, 2'd0);
    cyc();
    in_valid = 1'b0;
    held = out_instr;
    check("hold_valid", 32'(out_valid), 32'h1);
    cyc();
    check("hold_still_valid", 32'(out_valid), 32'h1);
    check("hold_stable", out_instr, 32'h0000_0013);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'h0);
    // Flush with a concurrent handshake: dropped but counted
    flush = 1'b1;
    fetch(32'hD190_2457, 30'h0, 2'd0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_hs_valid", 32'(out_valid), 32'h0);
    check("flush_hs_cnt", fetch_cnt, 32'd10);
    $display("step flush held=%h", held);

    // Reset while a word is held
    key_lock = 1'b1;
    cyc();
    key_lock = 1'b0;
    fetch(32'h0000_A111, 30'h5, 2'd3);
    cyc();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    check("pre_rst_ill", 32'(out_ill), 32'h1);
    check("pre_rst_locked", 32'(key_locked), 32'h1);
    rst = 1'b1;
    cyc();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_instr", out_instr, 32'h0);
    check("mid_rst_comp", 32'(out_comp), 32'h0);
    check("mid_rst_ill", 32'(out_ill), 32'h0);
    check("mid_rst_locked", 32'(key_locked), 32'h0);
    check("mid_rst_err", 32'(key_err), 32'h0);
    check("mid_rst_cnt", fetch_cnt, 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    cyc();
    $display("step reset mid-stream");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
